// File: rtl/vga_if.sv
// VGA raster bundle: pixel position, sync/blank flags and colour.
// The timing generator drives it through the out modport; draw stages consume it through in.
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        hblnk;
  logic        vsync;
  logic        vblnk;
  logic [11:0] rgb;

  modport out (
    output hcount, vcount, hsync, hblnk, vsync, vblnk, rgb
  );

  modport in (
    input hcount, vcount, hsync, hblnk, vsync, vblnk, rgb
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: registered counters, sync and blank flags, plus a frame_start pulse.
// Optional 16-bit frame counter is enabled by defining VGA_TIMING_FRAME_CNT_EN.
module vga_timing_gen #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 40,
  parameter int H_SYNC   = 128,
  parameter int H_BP     = 88,
  parameter int V_ACTIVE = 600,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 4,
  parameter int V_BP     = 23,
  parameter bit SYNC_POL = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pix_en,
  vga_if.out         vga_out,
`ifdef VGA_TIMING_FRAME_CNT_EN
  output logic       frame_start,
  output logic [15:0] frame_cnt
`else
  output logic       frame_start
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // 12-bit thresholds so a sync window ending exactly at 2048 still compares correctly.
  localparam logic [11:0] H_BLANK_START = 12'(H_ACTIVE);
  localparam logic [11:0] H_SYNC_START  = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] H_SYNC_END    = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] V_BLANK_START = 12'(V_ACTIVE);
  localparam logic [11:0] V_SYNC_START  = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] V_SYNC_END    = 12'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [10:0] H_LAST        = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST        = 11'(V_TOTAL - 1);

  generate
    if (H_TOTAL > 2048 || V_TOTAL > 2048) begin : g_total_too_big
      $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 2048");
    end
  endgenerate

  logic        rst_meta;
  logic        rst_sync;
  logic        advance;
  logic        h_last;
  logic        v_last;
  logic [10:0] h_next;
  logic [10:0] v_next;
  logic        hblnk_next;
  logic        vblnk_next;
  logic        hsync_next;
  logic        vsync_next;

  logic [10:0] hcount_q;
  logic [10:0] vcount_q;
  logic        hsync_q;
  logic        hblnk_q;
  logic        vsync_q;
  logic        vblnk_q;

  // Reset asserts asynchronously but only releases the counters two clocks later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_meta <= 1'b0;
      rst_sync <= 1'b0;
    end else begin
      rst_meta <= 1'b1;
      rst_sync <= rst_meta;
    end
  end

  assign advance = pix_en & rst_sync;
  assign h_last  = (hcount_q == H_LAST);
  assign v_last  = (vcount_q == V_LAST);

  always_comb begin
    h_next = hcount_q;
    v_next = vcount_q;
    if (advance) begin
      if (h_last) begin
        h_next = 11'd0;
        v_next = v_last ? 11'd0 : vcount_q + 11'd1;
      end else begin
        h_next = hcount_q + 11'd1;
      end
    end
  end

  // Flags decode the next-state position so they land in the same cycle as the counters.
  always_comb begin
    hblnk_next = ({1'b0, h_next} >= H_BLANK_START);
    vblnk_next = ({1'b0, v_next} >= V_BLANK_START);
    hsync_next = (({1'b0, h_next} >= H_SYNC_START) && ({1'b0, h_next} < H_SYNC_END))
                 ? SYNC_POL : ~SYNC_POL;
    vsync_next = (({1'b0, v_next} >= V_SYNC_START) && ({1'b0, v_next} < V_SYNC_END))
                 ? SYNC_POL : ~SYNC_POL;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcount_q    <= 11'd0;
      vcount_q    <= 11'd0;
      hblnk_q     <= 1'b0;
      vblnk_q     <= 1'b0;
      hsync_q     <= ~SYNC_POL;
      vsync_q     <= ~SYNC_POL;
      frame_start <= 1'b0;
    end else begin
      hcount_q    <= h_next;
      vcount_q    <= v_next;
      hblnk_q     <= hblnk_next;
      vblnk_q     <= vblnk_next;
      hsync_q     <= hsync_next;
      vsync_q     <= vsync_next;
      frame_start <= advance & h_last & v_last;
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= 16'd0;
    end else if (advance && h_last && v_last) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end
`endif

  assign vga_out.hcount = hcount_q;
  assign vga_out.vcount = vcount_q;
  assign vga_out.hsync  = hsync_q;
  assign vga_out.hblnk  = hblnk_q;
  assign vga_out.vsync  = vsync_q;
  assign vga_out.vblnk  = vblnk_q;
  assign vga_out.rgb    = 12'h000;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default-timing instance for line-level checks, small instance (active-low sync) for frame wrap.
module tb_vga_timing_gen;

  localparam int A_HTOT = 1056;
  localparam int B_HTOT = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic pixEnA;
  logic pixEnB;
  logic fsA;
  logic fsB;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] fcA;
  logic [15:0] fcB;
`endif

  int vecCount = 0;
  int errCount = 0;
  int posAH = 0;
  int posAV = 0;
  int posBH = 0;
  int posBV = 0;

  vga_if vgaA();
  vga_if vgaB();

  always #5 clk = ~clk;

  vga_timing_gen dutA (
    .clk(clk), .rst_n(rst_n), .pix_en(pixEnA), .vga_out(vgaA.out),
`ifdef VGA_TIMING_FRAME_CNT_EN
    .frame_start(fsA), .frame_cnt(fcA)
`else
    .frame_start(fsA)
`endif
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(3),
    .SYNC_POL(1'b0)
  ) dutB (
    .clk(clk), .rst_n(rst_n), .pix_en(pixEnB), .vga_out(vgaB.out),
`ifdef VGA_TIMING_FRAME_CNT_EN
    .frame_start(fsB), .frame_cnt(fcB)
`else
    .frame_start(fsB)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vecCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic stepCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic moveA(input int h, input int v);
    stepCycles((v * A_HTOT + h) - (posAV * A_HTOT + posAH));
    posAH = h;
    posAV = v;
  endtask

  task automatic moveB(input int h, input int v);
    stepCycles((v * B_HTOT + h) - (posBV * B_HTOT + posBH));
    posBH = h;
    posBV = v;
  endtask

  task automatic applyStimulus();
    int guard;
    rst_n  = 1'b0;
    pixEnA = 1'b1;
    pixEnB = 1'b1;
    stepCycles(3);

    // Reset state
    checkOutput("rst_hcount", vgaA.hcount, 0);
    checkOutput("rst_vcount", vgaA.vcount, 0);
    checkOutput("rst_hsync",  vgaA.hsync, 0);
    checkOutput("rst_vsync",  vgaA.vsync, 0);
    checkOutput("rst_hblnk",  vgaA.hblnk, 0);
    checkOutput("rst_vblnk",  vgaA.vblnk, 0);
    checkOutput("rst_rgb",    vgaA.rgb, 0);
    checkOutput("rst_fs",     fsA, 0);
    checkOutput("rstB_hsync", vgaB.hsync, 1);
    checkOutput("rstB_vsync", vgaB.vsync, 1);
`ifdef VGA_TIMING_FRAME_CNT_EN
    checkOutput("rst_fcnt", fcA, 0);
`endif

    rst_n = 1'b1;
    stepCycles(1);
    checkOutput("rel_hcount", vgaA.hcount, 0);
    checkOutput("rel_vcount", vgaA.vcount, 0);
    checkOutput("rel_hsync",  vgaA.hsync, 0);
    checkOutput("rel_hblnk",  vgaA.hblnk, 0);
    checkOutput("rel_fs",     fsA, 0);
    guard = 0;
    while (vgaA.hcount == 11'd0 && guard < 8) begin
      stepCycles(1);
      guard++;
    end
    checkOutput("start_hcount", vgaA.hcount, 1);
    checkOutput("start_fs", fsA, 0);
    pixEnB = 1'b0;
    posAH = 1;
    posAV = 0;

    // Hold with pix_en low
    moveA(300, 0);
    pixEnA = 1'b0;
    stepCycles(10);
    checkOutput("hold_hcount", vgaA.hcount, 300);
    checkOutput("hold_vcount", vgaA.vcount, 0);
    checkOutput("hold_hblnk",  vgaA.hblnk, 0);
    checkOutput("hold_hsync",  vgaA.hsync, 0);
    pixEnA = 1'b1;
    stepCycles(1);
    checkOutput("resume_hcount", vgaA.hcount, 301);
    posAH = 301;

    // Horizontal blank and sync edges
    moveA(799, 0);
    checkOutput("h799_hblnk", vgaA.hblnk, 0);
    moveA(800, 0);
    checkOutput("h800_hcount", vgaA.hcount, 800);
    checkOutput("h800_hblnk", vgaA.hblnk, 1);
    moveA(839, 0);
    checkOutput("h839_hsync", vgaA.hsync, 0);
    moveA(840, 0);
    checkOutput("h840_hsync", vgaA.hsync, 1);
    moveA(967, 0);
    checkOutput("h967_hsync", vgaA.hsync, 1);
    moveA(968, 0);
    checkOutput("h968_hsync", vgaA.hsync, 0);
    checkOutput("h968_vblnk", vgaA.vblnk, 0);

    // Line wrap
    moveA(1055, 5);
    checkOutput("l5_hcount", vgaA.hcount, 1055);
    checkOutput("l5_vcount", vgaA.vcount, 5);
    checkOutput("l5_hblnk",  vgaA.hblnk, 1);
    moveA(0, 6);
    checkOutput("l6_hcount", vgaA.hcount, 0);
    checkOutput("l6_vcount", vgaA.vcount, 6);
    checkOutput("l6_hblnk",  vgaA.hblnk, 0);
    checkOutput("l6_fs",     fsA, 0);

    // Asynchronous reset mid-frame
    moveA(500, 6);
    rst_n = 1'b0;
    #1;
    checkOutput("arst_hcount", vgaA.hcount, 0);
    checkOutput("arst_vcount", vgaA.vcount, 0);
    checkOutput("arst_hblnk",  vgaA.hblnk, 0);
    checkOutput("arst_hsync",  vgaA.hsync, 0);
    stepCycles(2);
    pixEnB = 1'b1;
    rst_n = 1'b1;
    guard = 0;
    while (vgaA.hcount == 11'd0 && guard < 8) begin
      stepCycles(1);
      guard++;
    end
    checkOutput("restart_hcount", vgaA.hcount, 1);
    checkOutput("restart_vcount", vgaA.vcount, 0);
    checkOutput("restartB_hcount", vgaB.hcount, 1);
    pixEnA = 1'b0;
    posBH = 1;
    posBV = 0;

    // Small instance: active-low sync windows
    moveB(9, 0);
    checkOutput("b9_hsync", vgaB.hsync, 1);
    moveB(10, 0);
    checkOutput("b10_hsync", vgaB.hsync, 0);
    moveB(12, 0);
    checkOutput("b12_hsync", vgaB.hsync, 0);
    moveB(13, 0);
    checkOutput("b13_hsync", vgaB.hsync, 1);
    moveB(0, 6);
    checkOutput("bl6_vblnk", vgaB.vblnk, 1);
    checkOutput("bl6_vsync", vgaB.vsync, 1);
    moveB(0, 7);
    checkOutput("bl7_vsync", vgaB.vsync, 0);
    moveB(15, 8);
    checkOutput("bl8_vsync", vgaB.vsync, 0);
    moveB(0, 9);
    checkOutput("bl9_vsync", vgaB.vsync, 1);

    // Frame wrap
    moveB(15, 11);
    checkOutput("bend_hblnk", vgaB.hblnk, 1);
    checkOutput("bend_fs", fsB, 0);
`ifdef VGA_TIMING_FRAME_CNT_EN
    checkOutput("bend_fcnt", fcB, 0);
`endif
    stepCycles(1);
    checkOutput("wrap_hcount", vgaB.hcount, 0);
    checkOutput("wrap_vcount", vgaB.vcount, 0);
    checkOutput("wrap_fs", fsB, 1);
    checkOutput("wrap_vblnk", vgaB.vblnk, 0);
`ifdef VGA_TIMING_FRAME_CNT_EN
    checkOutput("wrap_fcnt", fcB, 1);
`endif
    pixEnB = 1'b0;
    stepCycles(1);
    checkOutput("stall_fs", fsB, 0);
    checkOutput("stall_hcount", vgaB.hcount, 0);
    pixEnB = 1'b1;
    stepCycles(1);
    checkOutput("after_hcount", vgaB.hcount, 1);
    checkOutput("after_fs", fsB, 0);
`ifdef VGA_TIMING_FRAME_CNT_EN
    checkOutput("after_fcnt", fcB, 1);
`endif
  endtask

  initial begin
    applyStimulus();
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
